seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Downstream consumer of the processor top's 16-bit `test_value` debug output. It shows the value as four hex digits on a multiplexed common-anode 7-segment display. It snapshots `test_value` once per scan frame, so the display never tears mid-frame. It time-multiplexes the digits with a programmable refresh divider and an anti-ghosting blank gap, and it supports freeze and leading-zero blanking.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit slot lasts. Must be ≥ 2.
- `BLANK_CYC`, default 500: cycles at the start of each slot with all anodes off. Must be < `REFRESH_DIV`.
- `SEG_ACTIVE_LOW`, default 1: invert `seg` and `dp` when 1.
- `AN_ACTIVE_LOW`, default 1: invert `an` when 1.

Ports:
- `CLK`, input, 1: single clock; everything is on the rising edge.
- `RESET`, input, 1: asynchronous, active-high; clears all state immediately.
- `test_value`, input, 16: value to display; digit i shows `test_value[4i+3:4i]`.
- `freeze`, input, 1: when 1, the snapshot is not updated.
- `blank_lz`, input, 1: when 1, leading-zero blanking is enabled.
- `seg`, output, 7: segment drive `{g,f,e,d,c,b,a}`.
- `dp`, output, 1: decimal point; lit on digit 0 while freeze is active.
- `an`, output, 4: digit enables; `an[i]` selects digit i.
- `shown_value`, output, 16: current snapshot register, for observation.

## Operation
State:
- `div_cnt`: counts 0..`REFRESH_DIV`-1.
- `dig_idx`: 2-bit digit index.
- `shadow`: 16-bit snapshot.
- `frz_q`: registered copy of `freeze`.

Divider and scan:
- `div_cnt` increments every cycle.
- At `REFRESH_DIV`-1 it wraps to 0 and `dig_idx` advances 0→1→2→3→0 (mod 4).

Snapshot:
- Updates on the cycle where `dig_idx` goes 3→0 and `freeze`=0: `shadow <= test_value`.
- Otherwise `shadow` holds.
- `shown_value = shadow`.

Hex decode (active-high pattern, before polarity inversion):

| Nibble | Pattern | | Nibble | Pattern |
|---|---|---|---|---|
| 0 | 0111111 | | 8 | 1111111 |
| 1 | 0000110 | | 9 | 1101111 |
| 2 | 1011011 | | A | 1110111 |
| 3 | 1001111 | | b | 1111100 |
| 4 | 1100110 | | C | 0111001 |
| 5 | 1101101 | | d | 1011110 |
| 6 | 1111101 | | E | 1111001 |
| 7 | 0000111 | | F | 1110001 |

Leading-zero blanking:
- With `blank_lz`=1, digit i (i ≥ 1) is blanked when `shadow[15:4i]` == 0.
- Digit 0 is never blanked.
- A blanked digit drives pattern 0000000 but its anode is still enabled.

Anode drive:
- While `div_cnt` < `BLANK_CYC`, all anodes are inactive.
- Otherwise only `an[dig_idx]` is active.

Decimal point:
- `dp` is active when `dig_idx`==0, `frz_q`=1, and the slot is outside the blank gap.

Polarity:
- Apply `SEG_ACTIVE_LOW` / `AN_ACTIVE_LOW` inversion as the last step.

## Timing
- `seg`, `dp`, and `an` are registered. Their value in cycle t+1 is a function of `div_cnt`, `dig_idx`, `shadow`, `frz_q`, and `blank_lz` in cycle t.
- Output latency from state is one cycle.
- `test_value`-to-display latency is at most 4·`REFRESH_DIV`+1 cycles: capture waits for the next frame wrap, plus one output register stage.
- Reset (async, any time including mid-slot):
  - `div_cnt`=0, `dig_idx`=0, `shadow`=0, `frz_q`=0.
  - All anodes inactive, all segments off, `dp` off, at the polarity-applied levels.
- First cycle after reset release: state 0, so the output register loads an all-off value (blank gap).
- Digit 0 shows "0" starting at the edge after `div_cnt` reaches `BLANK_CYC`.
- `freeze` rising on the same cycle as the 3→0 wrap: capture is suppressed.
- `freeze` falling on a wrap cycle: capture occurs.
- `test_value` changing mid-frame has no visible effect until the next wrap.
- Counter wrap takes priority: no special cases at `REFRESH_DIV`-1 beyond the advance.

## Test plan
Bench settings: `REFRESH_DIV`=4, `BLANK_CYC`=1, both polarities active-low.

1. Reset behaviour: assert `RESET` mid-slot. Required: `an`=1111, `seg`=1111111, `dp`=1, and `shown_value`=0 within the same cycle. After release, 0 and 1 cycles later, `an` stays 1111.
2. Basic scan: `test_value`=16'h1A2F, `blank_lz`=0. Required after the first wrap: `shown_value`=1A2F. Per slot, `an` is 1110/1101/1011/0111 with `seg` = F(0001110) / 2(0100100) / A(0001000) / 1(1111001). The blank cycle has `an`=1111.
3. Frame coherency: change `test_value` from 16'h1234 to 16'hABCD while `dig_idx`=1. Required: `shown_value` stays 1234 until the 3→0 wrap, then becomes ABCD.
4. Freeze: assert `freeze` with `shown_value`=1234, then set `test_value`=16'hFFFF for 3 frames. Required: `shown_value` stays 1234 and `dp`=0 during digit 0. After release, FFFF appears at the next wrap.
5. Leading-zero blanking: `test_value`=16'h0050, `blank_lz`=1. Required: digits 3 and 2 show `seg`=1111111 with the anode enabled, digit 1 shows "5", digit 0 shows "0". Then 16'h0000: only digit 0 shows "0".
6. Simultaneous wrap and freeze: assert `freeze` exactly on the 3→0 wrap cycle while `test_value` differs from `shadow`. Required: no capture.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed hex display driver for the 16-bit test_value debug bus.
// The value is snapshotted once per scan frame; outputs are registered with selectable polarity.
module seg7_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] test_value,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] shown_value
);

  localparam int             CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  LP_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  LP_BLANK  = CW'(BLANK_CYC);
  // XOR masks that turn active-high drive into the pin polarity; also the "all off" levels.
  localparam logic [6:0]     LP_SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic           LP_DP_INV  = SEG_ACTIVE_LOW;
  localparam logic [3:0]     LP_AN_INV  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [CW-1:0] r_div_cnt;
  logic [1:0]    r_dig_idx;
  logic [15:0]   r_shadow;
  logic          r_frz_q;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;

  logic          w_slot_end;
  logic          w_frame_end;
  logic          w_in_gap;
  logic [3:0]    w_nibble;
  logic [15:0]   w_upper;
  logic          w_lz_blank;
  logic [6:0]    w_pattern;
  logic [6:0]    w_seg_hi;
  logic [3:0]    w_an_hi;
  logic          w_dp_hi;

  assign w_slot_end  = (r_div_cnt == LP_LAST);
  assign w_frame_end = w_slot_end && (r_dig_idx == 2'd3);
  assign w_in_gap    = (r_div_cnt < LP_BLANK);
  assign w_nibble    = r_shadow[{r_dig_idx, 2'b00} +: 4];
  assign w_upper     = r_shadow >> {r_dig_idx, 2'b00};
  assign w_lz_blank  = blank_lz && (r_dig_idx != 2'd0) && (w_upper == 16'h0000);

  always_comb begin
    w_pattern = 7'b0000000;
    case (w_nibble)
      4'h0: w_pattern = 7'b0111111;
      4'h1: w_pattern = 7'b0000110;
      4'h2: w_pattern = 7'b1011011;
      4'h3: w_pattern = 7'b1001111;
      4'h4: w_pattern = 7'b1100110;
      4'h5: w_pattern = 7'b1101101;
      4'h6: w_pattern = 7'b1111101;
      4'h7: w_pattern = 7'b0000111;
      4'h8: w_pattern = 7'b1111111;
      4'h9: w_pattern = 7'b1101111;
      4'hA: w_pattern = 7'b1110111;
      4'hB: w_pattern = 7'b1111100;
      4'hC: w_pattern = 7'b0111001;
      4'hD: w_pattern = 7'b1011110;
      4'hE: w_pattern = 7'b1111001;
      4'hF: w_pattern = 7'b1110001;
      default: w_pattern = 7'b0000000;
    endcase
  end

  // Segments are also dark during the gap so nothing ghosts onto the next digit.
  assign w_seg_hi = (w_in_gap || w_lz_blank) ? 7'b0000000 : w_pattern;
  assign w_an_hi  = w_in_gap ? 4'b0000 : (4'b0001 << r_dig_idx);
  assign w_dp_hi  = (r_dig_idx == 2'd0) && r_frz_q && !w_in_gap;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div_cnt <= '0;
      r_dig_idx <= 2'd0;
      r_shadow  <= 16'h0000;
      r_frz_q   <= 1'b0;
      r_seg     <= LP_SEG_INV;
      r_dp      <= LP_DP_INV;
      r_an      <= LP_AN_INV;
    end else begin
      r_frz_q <= freeze;
      if (w_slot_end) begin
        r_div_cnt <= '0;
        r_dig_idx <= r_dig_idx + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      // Live freeze input decides capture, so a freeze asserted on the wrap cycle wins.
      if (w_frame_end && !freeze) begin
        r_shadow <= test_value;
      end
      r_seg <= w_seg_hi ^ LP_SEG_INV;
      r_dp  <= w_dp_hi ^ LP_DP_INV;
      r_an  <= w_an_hi ^ LP_AN_INV;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign shown_value = r_shadow;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-cycle slot and a 1-cycle blank gap.
// Cycle n is counted from reset release; outputs after edge n reflect state after edge n-1.
module tb_seg7_scan_driver;

  logic        CLK;
  logic        RESET;
  logic [15:0] test_value;
  logic        freeze;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] shown_value;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  seg7_scan_driver #(
    .REFRESH_DIV   (4),
    .BLANK_CYC     (1),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .test_value (test_value),
    .freeze     (freeze),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .shown_value(shown_value)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", tag, obs, exp, cyc);
    end else begin
      $display("ok   %s = %h (cyc %0d)", tag, obs, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check_disp(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    check_eq({tag, ".an"}, 32'(an), 32'(an_exp));
    check_eq({tag, ".seg"}, 32'(seg), 32'(seg_exp));
  endtask

  initial begin
    RESET      = 1'b1;
    test_value = 16'h0000;
    freeze     = 1'b0;
    blank_lz   = 1'b0;
    tick();
    tick();
    check_eq("init_rst.an", 32'(an), 32'h0000000F);
    check_eq("init_rst.seg", 32'(seg), 32'h0000007F);
    check_eq("init_rst.dp", 32'(dp), 32'h00000001);
    check_eq("init_rst.shown", 32'(shown_value), 32'h00000000);
    RESET = 1'b0;
    cyc   = 0;

    // Basic scan of 1A2F, captured at the first frame wrap (edge 16).
    test_value = 16'h1A2F;
    wait_to(15);
    check_eq("scan.pre_wrap_shown", 32'(shown_value), 32'h00000000);
    wait_to(16);
    check_eq("scan.shown", 32'(shown_value), 32'h00001A2F);
    wait_to(17);
    check_eq("scan.gap0.an", 32'(an), 32'h0000000F);
    wait_to(19);
    check_disp("scan.dig0_F", 4'b1110, 7'b0001110);
    check_eq("scan.dig0.dp", 32'(dp), 32'h00000001);
    wait_to(21);
    check_eq("scan.gap1.an", 32'(an), 32'h0000000F);
    wait_to(23);
    check_disp("scan.dig1_2", 4'b1101, 7'b0100100);
    wait_to(27);
    check_disp("scan.dig2_A", 4'b1011, 7'b0001000);
    wait_to(31);
    check_disp("scan.dig3_1", 4'b0111, 7'b1111001);

    // Frame coherency: mid-frame change only lands at the next wrap.
    wait_to(32);
    test_value = 16'h1234;
    wait_to(48);
    check_eq("coh.shown_1234", 32'(shown_value), 32'h00001234);
    wait_to(53);
    test_value = 16'hABCD;
    wait_to(63);
    check_eq("coh.hold_1234", 32'(shown_value), 32'h00001234);
    wait_to(64);
    check_eq("coh.shown_ABCD", 32'(shown_value), 32'h0000ABCD);

    // Freeze: snapshot holds 1234 for three frames, dp lit on digit 0.
    test_value = 16'h1234;
    wait_to(80);
    check_eq("frz.shown_1234", 32'(shown_value), 32'h00001234);
    freeze     = 1'b1;
    test_value = 16'hFFFF;
    wait_to(83);
    check_eq("frz.dig0.dp", 32'(dp), 32'h00000000);
    check_eq("frz.dig0.an", 32'(an), 32'h0000000E);
    wait_to(85);
    check_eq("frz.gap1.dp", 32'(dp), 32'h00000001);
    wait_to(96);
    check_eq("frz.hold1", 32'(shown_value), 32'h00001234);
    wait_to(99);
    check_eq("frz.dig0.dp2", 32'(dp), 32'h00000000);
    wait_to(112);
    check_eq("frz.hold2", 32'(shown_value), 32'h00001234);
    wait_to(128);
    check_eq("frz.hold3", 32'(shown_value), 32'h00001234);
    wait_to(130);
    freeze = 1'b0;
    wait_to(143);
    check_eq("frz.prewrap", 32'(shown_value), 32'h00001234);
    wait_to(144);
    check_eq("frz.release_FFFF", 32'(shown_value), 32'h0000FFFF);

    // Leading-zero blanking on 0050, then 0000.
    test_value = 16'h0050;
    blank_lz   = 1'b1;
    wait_to(163);
    check_disp("lz50.dig0_0", 4'b1110, 7'b1000000);
    wait_to(167);
    check_disp("lz50.dig1_5", 4'b1101, 7'b0010010);
    wait_to(171);
    check_disp("lz50.dig2_blank", 4'b1011, 7'b1111111);
    wait_to(175);
    check_disp("lz50.dig3_blank", 4'b0111, 7'b1111111);
    wait_to(176);
    test_value = 16'h0000;
    wait_to(195);
    check_disp("lz00.dig0_0", 4'b1110, 7'b1000000);
    wait_to(199);
    check_disp("lz00.dig1_blank", 4'b1101, 7'b1111111);
    wait_to(203);
    check_disp("lz00.dig2_blank", 4'b1011, 7'b1111111);
    wait_to(207);
    check_disp("lz00.dig3_blank", 4'b0111, 7'b1111111);

    // Freeze rising on the wrap cycle suppresses capture; falling on a wrap allows it.
    wait_to(208);
    blank_lz   = 1'b0;
    test_value = 16'hBEEF;
    wait_to(223);
    freeze = 1'b1;
    wait_to(224);
    check_eq("wrapfrz.no_capture", 32'(shown_value), 32'h00000000);
    wait_to(239);
    freeze = 1'b0;
    wait_to(240);
    check_eq("wrapfrz.fall_capture", 32'(shown_value), 32'h0000BEEF);

    // Asynchronous reset asserted mid-slot.
    wait_to(242);
    check_eq("rst.pre.an", 32'(an), 32'h0000000E);
    #2;
    RESET = 1'b1;
    #1;
    check_eq("rst.async.an", 32'(an), 32'h0000000F);
    check_eq("rst.async.seg", 32'(seg), 32'h0000007F);
    check_eq("rst.async.dp", 32'(dp), 32'h00000001);
    check_eq("rst.async.shown", 32'(shown_value), 32'h00000000);
    tick();
    tick();
    RESET = 1'b0;
    cyc   = 0;
    check_eq("rst.rel0.an", 32'(an), 32'h0000000F);
    tick();
    check_eq("rst.rel1.an", 32'(an), 32'h0000000F);
    wait_to(2);
    check_disp("rst.first_dig0", 4'b1110, 7'b1000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
